mips_reg_dump: RTL and testbench
================================

Name: mips_reg_dump

Overview:
- Read-side sequencer for the MIPS register file. On request, it walks a contiguous (wrapping) range of register addresses through one register-file read port.
- Each word read is captured and streamed out on a valid/ready interface for the debug/testbench register-dump path.
- While a word is held, the block snoops the writeback port and flags the held word stale if its register is overwritten before the word is accepted.

Parameters:
DATA_WIDTH, 32, register word width
ADDR_WIDTH, 5, register address width (2^ADDR_WIDTH registers)

Ports:
CLK  input  1  clock, all state updates on rising edge
rst  input  1  reset, asynchronous, active-low (rst=0 resets)
start  input  1  request a dump; sampled only in IDLE
first_addr  input  ADDR_WIDTH  first register of range; latched on accepted start
last_addr  input  ADDR_WIDTH  last register of range; latched on accepted start
busy  output  1  high in RUN and DONE
done  output  1  one-cycle pulse in DONE
RdAddress  output  ADDR_WIDTH  drives register-file read address
RdData  input  DATA_WIDTH  combinational read data for RdAddress
RegWrite  input  1  writeback enable (snoop)
WriteAddress  input  ADDR_WIDTH  writeback address (snoop)
dump_valid  output  1  output word valid
dump_ready  input  1  consumer accepts when valid&&ready
dump_data  output  DATA_WIDTH  captured register value
dump_index  output  ADDR_WIDTH  register number of dump_data
dump_last  output  1  dump_data is the final word of the range
dump_stale  output  1  held word overwritten before acceptance

Behaviour:
- Reset (rst=0, async): state=IDLE. busy, done, dump_valid, dump_last and dump_stale are 0. dump_data, dump_index and RdAddress are 0. Effect is immediate, including mid-dump; all progress is discarded.
- States:
  - IDLE: RdAddress=0. start=1 → latch ptr<=first_addr, end<=last_addr, clear issued_all, go RUN.
  - RUN: see below.
  - DONE: done=1 for exactly one cycle, then IDLE.
- start outside IDLE is ignored.
- RUN:
  - RdAddress=ptr (combinational from register).
  - load = (!dump_valid || dump_ready) && !issued_all.
  - On load:
    - dump_data<=RdData, dump_index<=ptr, dump_last<=(ptr==end), dump_valid<=1.
    - dump_stale<=(RegWrite && WriteAddress==ptr && WriteAddress!=0): a same-edge write is not bypassed.
    - ptr<=ptr+1 (mod 2^ADDR_WIDTH). If ptr==end, issued_all<=1.
  - valid&&ready with no load → dump_valid<=0.
  - valid&&ready&&dump_last → DONE on the next edge. dump_valid<=0.
- Throughput: one word per cycle when dump_ready=1.
- Latency: start edge → first dump_valid after 2 rising edges (IDLE→RUN, then load).
- Hold rule: while dump_valid=1 and not accepted, dump_data, dump_index and dump_last are stable.
- Stale snoop: while dump_valid=1 and no load occurs that cycle, RegWrite && WriteAddress==dump_index && WriteAddress!=0 → dump_stale<=1. It is sticky until the next load.
- Range: word count = ((last_addr - first_addr) mod 2^ADDR_WIDTH) + 1.
  - first==last → 1 word.
  - first>last wraps through 31→0.
  - first=0, last=31 → 32 words.
- Register 0 is read as returned by the register file (0). It gets no special casing except being excluded from stale detection.
- dump_ready is don't-care while dump_valid=0.

Test Plan:
- Full dump:
  - Stimulus: preload r[i]=i*0x11 (r0=0), first=0, last=31, dump_ready=1.
  - Response: 32 consecutive beats, index 0..31, data i*0x11. dump_last only on index 31. done pulses once, the cycle after the last handshake. busy=0 afterwards.
- Backpressure:
  - Stimulus: first=4, last=6, dump_ready pattern 0,1,0,0,1,1.
  - Response: exactly r4, r5, r6 in order, each held stable until accepted. No duplicates or drops. dump_last with index 6.
- Wrap:
  - Stimulus: first=30, last=1.
  - Response: indices 30, 31, 0, 1. Data for index 0 = 0x00000000. Count = 4.
- Stale snoop:
  - Stimulus: r5=0x1234, first=last=5, dump_ready=0. While held, RegWrite with WriteAddress=5, DataIn=0xDEAD.
  - Response: dump_data stays 0x1234 and dump_stale=1.
  - Repeat with WriteAddress=0: dump_stale stays 0.
- Same-edge write:
  - Stimulus: RegWrite to WriteAddress=7 on the load cycle of index 7.
  - Response: captured data is the old r7 and dump_stale=1.
- Control:
  - start pulses while busy are ignored (range unchanged).
  - rst=0 mid-dump clears all outputs immediately, without waiting for a clock edge.
  - After release, a new start with first=2, last=3 yields r2, r3.

Source files
------------

// File: rtl/mips_reg_dump.sv
// Register-file dump sequencer: walks a wrapping address range through one read
// port and streams each word on valid/ready, flagging words overwritten while held.
module mips_reg_dump #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  CLK,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] first_addr,
  input  logic [ADDR_WIDTH-1:0] last_addr,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] RdAddress,
  input  logic [DATA_WIDTH-1:0] RdData,
  input  logic                  RegWrite,
  input  logic [ADDR_WIDTH-1:0] WriteAddress,
  output logic                  dump_valid,
  input  logic                  dump_ready,
  output logic [DATA_WIDTH-1:0] dump_data,
  output logic [ADDR_WIDTH-1:0] dump_index,
  output logic                  dump_last,
  output logic                  dump_stale
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] ptr_q;
  logic [ADDR_WIDTH-1:0] ptr_d;
  logic [ADDR_WIDTH-1:0] end_q;
  logic                  issued_all_q;
  logic                  valid_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [ADDR_WIDTH-1:0] index_q;
  logic                  last_q;
  logic                  stale_q;

  logic load;
  logic accept;
  logic load_hit;
  logic hold_hit;

  assign ptr_d  = ptr_q + 1'b1;
  assign accept = valid_q && dump_ready;
  assign load   = (state_q == RUN) && (!valid_q || dump_ready) && !issued_all_q;

  // A write landing on the same edge as the capture is not bypassed, so the
  // captured word is already out of date.
  assign load_hit = RegWrite && (WriteAddress == ptr_q) && (WriteAddress != '0);
  assign hold_hit = RegWrite && (WriteAddress == index_q) && (WriteAddress != '0);

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      end_q        <= '0;
      issued_all_q <= 1'b0;
      valid_q      <= 1'b0;
      data_q       <= '0;
      index_q      <= '0;
      last_q       <= 1'b0;
      stale_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            ptr_q        <= first_addr;
            end_q        <= last_addr;
            issued_all_q <= 1'b0;
            state_q      <= RUN;
          end
        end
        RUN: begin
          if (load) begin
            data_q  <= RdData;
            index_q <= ptr_q;
            last_q  <= (ptr_q == end_q);
            valid_q <= 1'b1;
            stale_q <= load_hit;
            ptr_q   <= ptr_d;
            if (ptr_q == end_q) begin
              issued_all_q <= 1'b1;
            end
          end else if (accept) begin
            valid_q <= 1'b0;
          end else if (valid_q && hold_hit) begin
            stale_q <= 1'b1;
          end
          // The last word is never followed by a load, so accepting it ends the run.
          if (accept && last_q) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign RdAddress  = (state_q == RUN) ? ptr_q : '0;
  assign dump_valid = valid_q;
  assign dump_data  = data_q;
  assign dump_index = index_q;
  assign dump_last  = last_q;
  assign dump_stale = stale_q;

endmodule

// File: tb/tb_mips_reg_dump.sv
// Bench for mips_reg_dump: register-file model, expected-beat queue filled at
// stimulus time, and a negedge monitor that pops and compares every handshake.
module tb_mips_reg_dump;
  localparam int DW   = 32;
  localparam int AW   = 5;
  localparam int NREG = 32;

  logic          CLK = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] first_addr;
  logic [AW-1:0] last_addr;
  logic          busy;
  logic          done;
  logic [AW-1:0] RdAddress;
  logic [DW-1:0] RdData;
  logic          RegWrite;
  logic [AW-1:0] WriteAddress;
  logic          dump_valid;
  logic          dump_ready;
  logic [DW-1:0] dump_data;
  logic [AW-1:0] dump_index;
  logic          dump_last;
  logic          dump_stale;

  logic [DW-1:0] wdata;
  logic [DW-1:0] regs [NREG];

  typedef struct {
    logic [AW-1:0] idx;
    logic [DW-1:0] data;
    logic          last;
    logic          stale;
  } exp_t;

  exp_t sb_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   done_cnt    = 0;

  always #5 CLK = ~CLK;

  mips_reg_dump #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .CLK(CLK), .rst(rst), .start(start), .first_addr(first_addr), .last_addr(last_addr),
    .busy(busy), .done(done), .RdAddress(RdAddress), .RdData(RdData),
    .RegWrite(RegWrite), .WriteAddress(WriteAddress),
    .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_data(dump_data),
    .dump_index(dump_index), .dump_last(dump_last), .dump_stale(dump_stale)
  );

  // Register file model: r0 hardwired to zero, combinational read, write on edge.
  function automatic logic [DW-1:0] rf_read(input logic [AW-1:0] a);
    return (a == '0) ? '0 : regs[a];
  endfunction

  assign RdData = rf_read(RdAddress);

  always @(posedge CLK) begin
    if (RegWrite && WriteAddress != '0) regs[WriteAddress] <= wdata;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic bit in_range(input logic [AW-1:0] a, input logic [AW-1:0] f,
                                  input logic [AW-1:0] l);
    logic [AW-1:0] da;
    logic [AW-1:0] dl;
    da = a - f;
    dl = l - f;
    return da <= dl;
  endfunction

  // Expected beats: every register from first to last (mod 32), in order.
  task automatic push_range(input logic [AW-1:0] f, input logic [AW-1:0] l);
    logic [AW-1:0] span;
    logic [AW-1:0] idx;
    exp_t          e;
    span = l - f;
    for (int k = 0; k <= int'(span); k++) begin
      idx     = f + AW'(k);
      e.idx   = idx;
      e.data  = rf_read(idx);
      e.last  = (idx == l);
      e.stale = 1'b0;
      sb_q.push_back(e);
    end
  endtask

  task automatic write_reg(input logic [AW-1:0] a, input logic [DW-1:0] d);
    RegWrite     = 1'b1;
    WriteAddress = a;
    wdata        = d;
    tick();
    RegWrite     = 1'b0;
  endtask

  task automatic wait_idle();
    int c;
    c = 0;
    while (busy && c < 300) begin
      tick();
      c++;
    end
    if (busy) fail_now("timeout_wait_idle");
  endtask

  task automatic finish_checks(input string name);
    check({name, "_done_count"}, done_cnt, 1);
    check({name, "_queue_left"}, sb_q.size(), 0);
    check({name, "_busy_after"}, busy, 0);
  endtask

  // mode 0: always ready; 1: ready pattern 0,1,0,0,1,1 then 1; 2: random ready,
  // random non-conflicting writes and ignored start pulses.
  task automatic run_dump(input logic [AW-1:0] f, input logic [AW-1:0] l, input int mode);
    logic [5:0]    pat;
    logic [AW-1:0] a;
    int            c;
    pat      = 6'b110010;
    done_cnt = 0;
    push_range(f, l);
    $display("dump first=%0d last=%0d mode=%0d", f, l, mode);
    first_addr = f;
    last_addr  = l;
    start      = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("valid_latency_0", dump_valid, 0);
    c = 0;
    while (busy && c < 400) begin
      case (mode)
        0: dump_ready = 1'b1;
        1: dump_ready = (c < 6) ? pat[c] : 1'b1;
        default: begin
          dump_ready   = 1'($urandom_range(0, 1));
          a            = AW'($urandom_range(0, NREG - 1));
          if (in_range(a, f, l)) a = '0;
          RegWrite     = 1'($urandom_range(0, 1));
          WriteAddress = a;
          wdata        = $urandom;
          start        = ($urandom_range(0, 5) == 0);
          first_addr   = AW'($urandom_range(0, NREG - 1));
          last_addr    = AW'($urandom_range(0, NREG - 1));
        end
      endcase
      tick();
      if (mode == 0 && c == 0) check("valid_latency_1", dump_valid, 1);
      c++;
    end
    start      = 1'b0;
    RegWrite   = 1'b0;
    dump_ready = 1'b0;
    if (busy) fail_now("timeout_dump");
    finish_checks("dump");
  endtask

  // Single held word at register 5, snooped write while dump_ready is low.
  task automatic stale_run(input logic [AW-1:0] wa, input logic exp_stale);
    exp_t e;
    int   c;
    done_cnt = 0;
    e.idx    = 5'd5;
    e.data   = rf_read(5'd5);
    e.last   = 1'b1;
    e.stale  = exp_stale;
    sb_q.push_back(e);
    $display("stale run write_addr=%0d", wa);
    dump_ready = 1'b0;
    first_addr = 5'd5;
    last_addr  = 5'd5;
    start      = 1'b1;
    tick();
    start = 1'b0;
    c = 0;
    while (!dump_valid && c < 20) begin
      tick();
      c++;
    end
    check("stale_valid_up", dump_valid, 1);
    write_reg(wa, 32'hDEAD);
    tick();
    tick();
    check("stale_data_held", dump_data, e.data);
    check("stale_flag", dump_stale, exp_stale);
    dump_ready = 1'b1;
    wait_idle();
    dump_ready = 1'b0;
    finish_checks("stale");
  endtask

  // Monitor: compares each handshake against the queue, checks hold stability
  // and that done follows the final handshake by one cycle.
  initial begin
    exp_t          e;
    bit            prev_hold;
    bit            prev_last_hs;
    logic [DW-1:0] pd;
    logic [AW-1:0] pi;
    logic          pl;
    prev_hold    = 1'b0;
    prev_last_hs = 1'b0;
    pd = '0;
    pi = '0;
    pl = 1'b0;
    forever begin
      @(negedge CLK);
      if (!rst) begin
        prev_hold    = 1'b0;
        prev_last_hs = 1'b0;
      end else begin
        if (done) begin
          done_cnt++;
          check("done_after_last", 32'(prev_last_hs), 1);
        end
        if (prev_hold) begin
          check("hold_valid", dump_valid, 1);
          check("hold_data", dump_data, pd);
          check("hold_index", dump_index, pi);
          check("hold_last", dump_last, pl);
        end
        if (dump_valid && dump_ready) begin
          $display("beat idx=%0d data=%h last=%0b stale=%0b",
                   dump_index, dump_data, dump_last, dump_stale);
          if (sb_q.size() == 0) begin
            fail_now("unexpected_beat");
          end else begin
            e = sb_q.pop_front();
            check("beat_index", dump_index, e.idx);
            check("beat_data", dump_data, e.data);
            check("beat_last", dump_last, e.last);
            check("beat_stale", dump_stale, e.stale);
          end
        end
        prev_last_hs = dump_valid && dump_ready && dump_last;
        prev_hold    = dump_valid && !dump_ready;
        pd = dump_data;
        pi = dump_index;
        pl = dump_last;
      end
    end
  end

  task automatic check_reset_outputs(input string name);
    check({name, "_busy"}, busy, 0);
    check({name, "_done"}, done, 0);
    check({name, "_valid"}, dump_valid, 0);
    check({name, "_last"}, dump_last, 0);
    check({name, "_stale"}, dump_stale, 0);
    check({name, "_data"}, dump_data, 0);
    check({name, "_index"}, dump_index, 0);
    check({name, "_rdaddr"}, RdAddress, 0);
  endtask

  initial begin
    logic [AW-1:0] rf;
    logic [AW-1:0] rl;
    exp_t          e;
    rst          = 1'b0;
    start        = 1'b0;
    first_addr   = '0;
    last_addr    = '0;
    RegWrite     = 1'b0;
    WriteAddress = '0;
    wdata        = '0;
    dump_ready   = 1'b0;
    #3;
    check_reset_outputs("reset");
    tick();
    tick();
    rst = 1'b1;
    tick();

    for (int i = 1; i < NREG; i++) write_reg(AW'(i), 32'(i) * 32'h11);

    run_dump(5'd0, 5'd31, 0);
    run_dump(5'd4, 5'd6, 1);
    run_dump(5'd30, 5'd1, 0);

    write_reg(5'd5, 32'h1234);
    stale_run(5'd5, 1'b1);
    stale_run(5'd0, 1'b0);

    // Write to r7 on the very edge that captures it: old value, flagged stale.
    done_cnt = 0;
    e.idx    = 5'd7;
    e.data   = rf_read(5'd7);
    e.last   = 1'b1;
    e.stale  = 1'b1;
    sb_q.push_back(e);
    $display("same-edge write run");
    dump_ready = 1'b1;
    first_addr = 5'd7;
    last_addr  = 5'd7;
    start      = 1'b1;
    tick();
    start        = 1'b0;
    RegWrite     = 1'b1;
    WriteAddress = 5'd7;
    wdata        = 32'hBEEF;
    tick();
    RegWrite = 1'b0;
    wait_idle();
    dump_ready = 1'b0;
    finish_checks("same_edge");

    for (int n = 0; n < 10; n++) begin
      rf = AW'($urandom_range(0, NREG - 1));
      rl = AW'($urandom_range(0, NREG - 1));
      run_dump(rf, rl, 2);
    end

    // Asynchronous reset in the middle of a long dump, away from any edge.
    $display("mid-dump reset run");
    push_range(5'd0, 5'd31);
    dump_ready = 1'b1;
    first_addr = 5'd0;
    last_addr  = 5'd31;
    start      = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    #2;
    rst = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    sb_q.delete();
    dump_ready = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    run_dump(5'd2, 5'd3, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
